// File: rtl/dmem_loader_pkg.sv
// rtl/dmem_loader_pkg.sv - shared types and constants for the DMEM image loader
package dmem_loader_pkg;

   `include "dmem_defs.vh"

   // Index of the final image byte; reaching it with MEM_RDY ends the load.
   localparam logic [DMEM_ADDR_W-1:0] LAST_IDX = DMEM_ADDR_W'(DMEM_BYTES - 1);

endpackage

// File: rtl/dmem_byte_sel.sv
// rtl/dmem_byte_sel.sv - 8:1 mux picking the image byte for the current load index
module dmem_byte_sel
   import dmem_loader_pkg::*;
(
   input  logic [DMEM_DATA_W-1:0] d0,
   input  logic [DMEM_DATA_W-1:0] d1,
   input  logic [DMEM_DATA_W-1:0] d2,
   input  logic [DMEM_DATA_W-1:0] d3,
   input  logic [DMEM_DATA_W-1:0] d4,
   input  logic [DMEM_DATA_W-1:0] d5,
   input  logic [DMEM_DATA_W-1:0] d6,
   input  logic [DMEM_DATA_W-1:0] d7,
   input  logic [DMEM_ADDR_W-1:0] sel,
   output logic [DMEM_DATA_W-1:0] q
);

   // Purely combinational: image bytes are used live, never captured.
   always_comb begin
      q = d0;
      case (sel)
         3'd0: q = d0;
         3'd1: q = d1;
         3'd2: q = d2;
         3'd3: q = d3;
         3'd4: q = d4;
         3'd5: q = d5;
         3'd6: q = d6;
         3'd7: q = d7;
         default: q = d0;
      endcase
   end

endmodule

// File: rtl/dmem_defs.vh
// rtl/dmem_defs.vh - DMEM geometry and loader state encodings
`ifndef DMEM_DEFS_VH
`define DMEM_DEFS_VH

localparam int DMEM_ADDR_W = 3;
localparam int DMEM_DATA_W = 8;
localparam int DMEM_BYTES  = 8;

typedef enum logic [1:0] {
   START = 2'd0,
   IDLE  = 2'd1,
   LOAD  = 2'd2,
   READY = 2'd3
} state_t;

`endif

// File: rtl/dmem_loader.sv
// rtl/dmem_loader.sv - copies an 8-byte image into DMEM and arbitrates the CPU write port
module dmem_loader
   import dmem_loader_pkg::*;
#(
   parameter int AUTO_LOAD = 1
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic [DMEM_DATA_W-1:0] D0,
   input  logic [DMEM_DATA_W-1:0] D1,
   input  logic [DMEM_DATA_W-1:0] D2,
   input  logic [DMEM_DATA_W-1:0] D3,
   input  logic [DMEM_DATA_W-1:0] D4,
   input  logic [DMEM_DATA_W-1:0] D5,
   input  logic [DMEM_DATA_W-1:0] D6,
   input  logic [DMEM_DATA_W-1:0] D7,
   input  logic                   RELOAD,
   input  logic                   CPU_WE,
   input  logic [DMEM_ADDR_W-1:0] CPU_ADDR,
   input  logic [DMEM_DATA_W-1:0] CPU_WDATA,
   input  logic                   MEM_RDY,
   output logic                   MEM_WE,
   output logic [DMEM_ADDR_W-1:0] MEM_ADDR,
   output logic [DMEM_DATA_W-1:0] MEM_WDATA,
   output logic                   CPU_STALL,
   output logic                   BUSY,
   output logic                   DONE
);

   state_t                 state;
   state_t                 next_state;
   logic [DMEM_ADDR_W-1:0] idx;
   logic                   done_q;
   logic [DMEM_DATA_W-1:0] img_byte;
   logic                   load_entry;
   logic                   last_write;

   dmem_byte_sel u_byte_sel (
      .d0  (D0),
      .d1  (D1),
      .d2  (D2),
      .d3  (D3),
      .d4  (D4),
      .d5  (D5),
      .d6  (D6),
      .d7  (D7),
      .sel (idx),
      .q   (img_byte)
   );

   // LOAD is entered only from another state, so idx restarts exactly once per load.
   assign load_entry = (state != LOAD) && (next_state == LOAD);
   assign last_write = (state == LOAD) && MEM_RDY && (idx == LAST_IDX);

   // State, index and completion flag; reset is synchronous only.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state  <= START;
         idx    <= '0;
         done_q <= 1'b0;
      end else begin
         state <= next_state;
         if (load_entry) begin
            idx <= '0;
         end else if ((state == LOAD) && MEM_RDY) begin
            idx <= idx + 3'd1;
         end
         if (last_write) begin
            done_q <= 1'b1;
         end else if (load_entry) begin
            done_q <= 1'b0;
         end
      end
   end

   // Next-state and write-port arbitration; loader owns DMEM outside IDLE/READY.
   always_comb begin
      next_state = state;
      MEM_WE     = 1'b0;
      MEM_ADDR   = '0;
      MEM_WDATA  = '0;
      CPU_STALL  = 1'b1;
      BUSY       = 1'b0;
      case (state)
         START: begin
            next_state = (AUTO_LOAD != 0) ? LOAD : IDLE;
         end
         IDLE, READY: begin
            MEM_WE    = CPU_WE;
            MEM_ADDR  = CPU_ADDR;
            MEM_WDATA = CPU_WDATA;
            CPU_STALL = 1'b0;
            if (RELOAD) begin
               next_state = LOAD;
            end
         end
         LOAD: begin
            MEM_WE    = 1'b1;
            MEM_ADDR  = idx;
            MEM_WDATA = img_byte;
            BUSY      = 1'b1;
            if (MEM_RDY && (idx == LAST_IDX)) begin
               next_state = READY;
            end
         end
         default: begin
            next_state = START;
         end
      endcase
   end

   assign DONE = done_q;

endmodule

// File: doc/dmem_loader.md
DMEM_LOADER -- requirements
Module: dmem_loader

Interface
REQ-001 SHALL have parameter AUTO_LOAD, default 1: 1 starts an image load automatically after reset; 0 waits in IDLE for RELOAD.
REQ-002 SHALL have port CLK, input, 1: single clock; all state changes on rising edge.
REQ-003 SHALL have port RST_N, input, 1: synchronous active-low reset, sampled on CLK rising edge.
REQ-004 SHALL have ports D0..D7, input, 8 each: preload image bytes; Dn is written to DMEM address n.
REQ-005 SHALL have port RELOAD, input, 1: request to re-copy the image into DMEM.
REQ-006 SHALL have ports CPU_WE (input, 1), CPU_ADDR (input, 3) and CPU_WDATA (input, 8): the CPU's DMEM write request.
REQ-007 SHALL have port MEM_RDY, input, 1: DMEM accepts the presented write this cycle.
REQ-008 SHALL have ports MEM_WE (output, 1), MEM_ADDR (output, 3) and MEM_WDATA (output, 8): the arbitrated DMEM write port.
REQ-009 SHALL have port CPU_STALL, output, 1: the loader owns DMEM and the CPU must hold.
REQ-010 SHALL have port BUSY, output, 1: high in state LOAD.
REQ-011 SHALL have port DONE, output, 1: a complete image is resident in DMEM.

Function
REQ-012 SHALL implement the FSM states START, IDLE, LOAD and READY.
REQ-013 START SHALL last exactly one cycle, then go to LOAD if AUTO_LOAD=1, else IDLE.
REQ-014 START outputs SHALL be: MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, CPU_STALL=1, BUSY=0, DONE=0.
REQ-015 LOAD outputs SHALL be: MEM_WE=1, MEM_ADDR=idx, MEM_WDATA=D[idx], CPU_STALL=1, BUSY=1.
REQ-016 idx SHALL be a 3-bit counter, cleared on entry to LOAD.
REQ-017 In LOAD with MEM_RDY=1, idx SHALL increment; with MEM_RDY=0, idx, address and data SHALL hold.
REQ-018 LOAD with idx=7 and MEM_RDY=1 SHALL go to READY; idx SHALL NOT wrap back into a ninth write.
REQ-019 DONE SHALL rise in the cycle after the last accepted write and stay high until RELOAD is accepted or reset.
REQ-020 IDLE and READY SHALL pass through the CPU port combinationally: MEM_WE=CPU_WE, MEM_ADDR=CPU_ADDR, MEM_WDATA=CPU_WDATA, CPU_STALL=0.
REQ-021 RELOAD=1 in IDLE or READY SHALL enter LOAD next cycle with idx=0 and DONE cleared that same cycle.
REQ-022 A CPU write presented in the same cycle as a RELOAD (IDLE/READY) SHALL still pass through that cycle.
REQ-023 RELOAD in START or LOAD SHALL be ignored; a load in progress is not restarted.
REQ-024 CPU_WE in START or LOAD SHALL NOT reach DMEM; the CPU holds its request under CPU_STALL.
REQ-025 With MEM_RDY held at 1, a load SHALL take exactly 8 LOAD cycles, so DONE rises 10 cycles after reset release (AUTO_LOAD=1).
REQ-026 D0..D7 SHALL be sampled at the cycle each byte is written and SHALL NOT be latched.

Reset
REQ-027 RST_N=0 at a rising edge SHALL force state=START, idx=0 and DONE=0, regardless of current state.
REQ-028 A reset asserted mid-LOAD SHALL abort the partial load and restart it per AUTO_LOAD.
REQ-029 The FSM SHALL have no asynchronous reset path.

Structure
REQ-030 Include file dmem_defs.vh SHALL hold the state encodings, DMEM_ADDR_W=3, DMEM_DATA_W=8 and DMEM_BYTES=8.
REQ-031 One sub-module, dmem_byte_sel, SHALL provide the 8:1 byte mux selecting D[idx].
REQ-032 The image source SHALL be instantiated outside dmem_loader and wired to D0..D7.

Verification
REQ-033 Scenario: AUTO_LOAD=1, MEM_RDY=1, D={22,A8,04,03,22,00,18,00}h -> writes (0,22h)..(7,00h) on consecutive cycles; DONE=1 in cycle 10 after reset release.
REQ-034 Scenario: MEM_RDY=0 for 3 cycles at idx=2 -> MEM_ADDR=2 and MEM_WDATA=04h hold; exactly 8 writes total; DONE delayed by 3 cycles.
REQ-035 Scenario: READY with CPU_WE=1, ADDR=5, WDATA=7Fh -> same cycle MEM_WE=1, MEM_ADDR=5, MEM_WDATA=7Fh, CPU_STALL=0.
REQ-036 Scenario: RELOAD and CPU write (3,55h) in the same READY cycle -> 55h written to address 3; next cycle BUSY=1, DONE=0, MEM_ADDR=0.
REQ-037 Scenario: RST_N=0 at idx=4 -> next cycle START with all MEM outputs 0; then a fresh load starts from address 0.
REQ-038 Scenario: AUTO_LOAD=0 -> FSM stays in IDLE, DONE=0 and MEM_WE tracks CPU_WE; a RELOAD pulse starts the load.
